// File: rtl/cpu_types_pkg.sv
// Shared cache types: FSM state encoding and address-field width helpers.
package cpu_types_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } icache_state_t;

  localparam int WORD_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int BYTE_OFF_W = 2;

  // Smallest r such that 2**r >= n.
  function automatic int log2_ceil(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Word-offset field width within a block.
  function automatic int offset_bits(input int blkwords);
    return log2_ceil(blkwords);
  endfunction

  // Set-index field width.
  function automatic int index_bits(input int sets);
    return log2_ceil(sets);
  endfunction

  // Tag field width: everything above byte offset, word offset and index.
  function automatic int tag_bits(input int sets, input int blkwords);
    return ADDR_W - BYTE_OFF_W - offset_bits(blkwords) - index_bits(sets);
  endfunction

  // Storage width for a field that may be zero bits wide.
  function automatic int field_w(input int bits);
    return (bits < 1) ? 1 : bits;
  endfunction

endpackage

// File: rtl/icache_way.sv
// One cache way: per-set valid bit, tag and block data, with tag compare.
module icache_way
  import cpu_types_pkg::*;
#(
  parameter int SETS     = 8,
  parameter int BLKWORDS = 2,
  parameter int IDX_W    = 3,
  parameter int OFF_W    = 1,
  parameter int TAG_W    = 26
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [IDX_W-1:0]  rd_index,
  input  logic [TAG_W-1:0]  rd_tag,
  input  logic [OFF_W-1:0]  rd_offset,
  output logic              match,
  output logic              valid,
  output logic [WORD_W-1:0] rd_word,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [OFF_W-1:0]  wr_offset,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              fill_done,
  input  logic [TAG_W-1:0]  wr_tag
);

  logic [SETS-1:0]   valid_r;
  logic [TAG_W-1:0]  tag_r  [SETS];
  logic [WORD_W-1:0] data_r [SETS][BLKWORDS];

  // Lookup: the line matches only when it is valid and its tag agrees.
  always_comb begin
    valid   = valid_r[rd_index];
    match   = valid_r[rd_index] && (tag_r[rd_index] == rd_tag);
    rd_word = data_r[rd_index][rd_offset];
  end

  // Storage update: flush drops valid bits and wins over a completing fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= '0;
      for (int s = 0; s < SETS; s++) begin
        tag_r[s] <= '0;
        for (int k = 0; k < BLKWORDS; k++) begin
          data_r[s][k] <= '0;
        end
      end
    end else begin
      if (flush) begin
        valid_r <= '0;
      end else if (fill_done) begin
        valid_r[wr_index] <= 1'b1;
        tag_r[wr_index]   <= wr_tag;
      end
      if (wr_en && !flush) begin
        data_r[wr_index][wr_offset] <= wr_data;
      end
    end
  end

endmodule

// File: rtl/icache_assoc.sv
// Set-associative instruction cache (1 or 2 ways) with block refill FSM.
module icache_assoc
  import cpu_types_pkg::*;
#(
  parameter int WAYS     = 2,
  parameter int SETS     = 8,
  parameter int BLKWORDS = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  input  logic        flush,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int OFF_BITS = offset_bits(BLKWORDS);
  localparam int IDX_BITS = index_bits(SETS);
  localparam int TAG_W    = tag_bits(SETS, BLKWORDS);
  localparam int OFF_W    = field_w(OFF_BITS);
  localparam int IDX_W    = field_w(IDX_BITS);
  localparam logic [31:0] BLK_MASK = ~(32'(BLKWORDS * 4) - 32'd1);

  // Address field extraction (shifts keep a zero-width offset field legal).
  function automatic logic [IDX_W-1:0] index_of(input logic [31:0] a);
    logic [31:0] t;
    t = a >> (BYTE_OFF_W + OFF_BITS);
    return t[IDX_W-1:0];
  endfunction

  function automatic logic [OFF_W-1:0] offset_of(input logic [31:0] a);
    logic [31:0] t;
    t = a >> BYTE_OFF_W;
    return t[OFF_W-1:0] & OFF_W'(BLKWORDS - 1);
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] a);
    logic [31:0] t;
    t = a >> (BYTE_OFF_W + OFF_BITS + IDX_BITS);
    return t[TAG_W-1:0];
  endfunction

  icache_state_t     state_r, state_nx;
  logic [OFF_W-1:0]  cnt_r;
  logic [31:0]       base_r;
  logic              victim_r;
  logic [SETS-1:0]   lru_r;
  logic [31:0]       hit_count_r, miss_count_r;

  logic [IDX_W-1:0]  req_index_s, fill_index_s;
  logic [TAG_W-1:0]  req_tag_s, fill_tag_s;
  logic [OFF_W-1:0]  req_offset_s;
  logic [WAYS-1:0]   match_s, valid_s;
  logic [WORD_W-1:0] way_word_s [WAYS];
  logic              lookup_ok_s, hit_s, miss_start_s;
  logic              hit_way_s, victim_s, victim_found_s;
  logic [WORD_W-1:0] hit_word_s;
  logic              fill_write_s, fill_last_s, fill_done_s;

  assign req_index_s  = index_of(imemaddr);
  assign req_tag_s    = tag_of(imemaddr);
  assign req_offset_s = offset_of(imemaddr);
  assign fill_index_s = index_of(base_r);
  assign fill_tag_s   = tag_of(base_r);

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    icache_way #(
      .SETS    (SETS),
      .BLKWORDS(BLKWORDS),
      .IDX_W   (IDX_W),
      .OFF_W   (OFF_W),
      .TAG_W   (TAG_W)
    ) u_way (
      .clk      (CLK),
      .rst      (RST),
      .flush    (flush),
      .rd_index (req_index_s),
      .rd_tag   (req_tag_s),
      .rd_offset(req_offset_s),
      .match    (match_s[g]),
      .valid    (valid_s[g]),
      .rd_word  (way_word_s[g]),
      .wr_en    (fill_write_s && (victim_r == 1'(g))),
      .wr_index (fill_index_s),
      .wr_offset(cnt_r),
      .wr_data  (iload),
      .fill_done(fill_done_s && (victim_r == 1'(g))),
      .wr_tag   (fill_tag_s)
    );
  end

  // Hit detection, hit-way select and victim choice (first invalid way, else LRU).
  always_comb begin
    lookup_ok_s    = (state_r == IDLE) && imemREN && !flush && !RST;
    hit_s          = lookup_ok_s && (|match_s);
    miss_start_s   = lookup_ok_s && !(|match_s);
    hit_way_s      = 1'b0;
    hit_word_s     = '0;
    victim_s       = lru_r[req_index_s];
    victim_found_s = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      hit_way_s  = match_s[w] ? 1'(w) : hit_way_s;
      hit_word_s = match_s[w] ? way_word_s[w] : hit_word_s;
      if (!victim_found_s && !valid_s[w]) begin
        victim_s       = 1'(w);
        victim_found_s = 1'b1;
      end else begin
        victim_found_s = victim_found_s;
      end
    end
  end

  // Fill progress: a word lands on each non-waiting cycle unless flushed.
  always_comb begin
    fill_write_s = (state_r == FILL) && !iwait && !flush && !RST;
    fill_last_s  = (cnt_r == OFF_W'(BLKWORDS - 1));
    fill_done_s  = fill_write_s && fill_last_s;
  end

  // Next-state logic for the IDLE/FILL controller.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE: begin
        if (miss_start_s) state_nx = FILL;
        else              state_nx = IDLE;
      end
      FILL: begin
        if (flush || fill_done_s) state_nx = IDLE;
        else                      state_nx = FILL;
      end
      default: state_nx = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) state_r <= IDLE;
    else     state_r <= state_nx;
  end

  // Miss capture (block base, victim) and word counter advance.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_r    <= '0;
      base_r   <= 32'd0;
      victim_r <= 1'b0;
    end else if (miss_start_s) begin
      cnt_r    <= '0;
      base_r   <= imemaddr & BLK_MASK;
      victim_r <= victim_s;
    end else if (fill_write_s) begin
      cnt_r <= fill_last_s ? '0 : cnt_r + OFF_W'(1);
    end
  end

  // Per-set LRU bit names the way to evict next; only meaningful with two ways.
  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      lru_r <= '0;
    end else if (WAYS == 2) begin
      if (hit_s)            lru_r[req_index_s]  <= ~hit_way_s;
      else if (fill_done_s) lru_r[fill_index_s] <= ~victim_r;
    end
  end

  // Saturating hit/miss statistics; flush leaves them alone.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_count_r  <= 32'd0;
      miss_count_r <= 32'd0;
    end else begin
      if (hit_s && (hit_count_r != 32'hFFFF_FFFF))
        hit_count_r <= hit_count_r + 32'd1;
      if (miss_start_s && (miss_count_r != 32'hFFFF_FFFF))
        miss_count_r <= miss_count_r + 32'd1;
    end
  end

  // Datapath and memory-side outputs; all zero when inactive.
  always_comb begin
    ihit       = hit_s;
    imemload   = hit_s ? hit_word_s : 32'd0;
    iREN       = (state_r == FILL) && !RST;
    iaddr      = iREN ? (base_r + (32'(cnt_r) << 2)) : 32'd0;
    hit_count  = hit_count_r;
    miss_count = miss_count_r;
  end

endmodule

// File: tb/tb_icache_assoc.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural cache model.
module tb_icache_assoc;

  localparam int WAYS = 2;
  localparam int SETS = 8;
  localparam int BW   = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b1, imemREN = 1'b0, flush = 1'b0, iwait = 1'b1;
  logic [31:0] imemaddr = 32'd0, iload = 32'd0;
  logic        ihit, iREN;
  logic [31:0] imemload, iaddr, hit_count, miss_count;

  always #5 CLK = ~CLK;

  icache_assoc #(.WAYS(WAYS), .SETS(SETS), .BLKWORDS(BW)) dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload), .flush(flush),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] memval(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
  endfunction

  // ---------------- behavioural model ----------------
  bit          m_valid [SETS][WAYS];
  int unsigned m_blk   [SETS][WAYS];
  logic [31:0] m_data  [SETS][WAYS][BW];
  int          m_lru   [SETS];
  bit          m_filling = 0;
  int unsigned m_fblk = 0;
  int          m_fway = 0;
  int          m_fcnt = 0;
  logic [31:0] m_hits = 32'd0, m_misses = 32'd0;
  bit          chk_en = 0;

  // Compare DUT against the model every cycle, then advance the model.
  always @(negedge CLK) begin
    if (chk_en) begin
      int unsigned blk;
      int s, hw, fs, v;
      logic        e_hit, e_ren;
      logic [31:0] e_load, e_addr;
      blk = imemaddr >> 3;
      s   = int'(blk % SETS);
      hw  = -1;
      for (int w = 0; w < WAYS; w++)
        if (m_valid[s][w] && m_blk[s][w] == blk) hw = w;
      e_hit = 0; e_ren = 0; e_load = 0; e_addr = 0;
      if (!RST) begin
        if (m_filling) begin
          e_ren  = 1;
          e_addr = 32'(m_fblk * 8 + 4 * m_fcnt);
        end else if (imemREN && !flush && hw >= 0) begin
          e_hit  = 1;
          e_load = m_data[s][hw][(imemaddr >> 2) % BW];
        end
      end
      chk("ihit", 32'(ihit), 32'(e_hit));
      chk("imemload", imemload, e_load);
      chk("iREN", 32'(iREN), 32'(e_ren));
      chk("iaddr", iaddr, e_addr);
      chk("hit_count", hit_count, m_hits);
      chk("miss_count", miss_count, m_misses);

      if (RST) begin
        for (int i = 0; i < SETS; i++) begin
          m_lru[i] = 0;
          for (int w = 0; w < WAYS; w++) m_valid[i][w] = 0;
        end
        m_filling = 0; m_hits = 0; m_misses = 0;
      end else if (flush) begin
        for (int i = 0; i < SETS; i++) begin
          m_lru[i] = 0;
          for (int w = 0; w < WAYS; w++) m_valid[i][w] = 0;
        end
        m_filling = 0;
      end else if (m_filling) begin
        if (!iwait) begin
          fs = int'(m_fblk % SETS);
          m_data[fs][m_fway][m_fcnt] = iload;
          m_fcnt++;
          if (m_fcnt == BW) begin
            m_valid[fs][m_fway] = 1;
            m_blk[fs][m_fway]   = m_fblk;
            m_lru[fs]           = 1 - m_fway;
            m_filling           = 0;
          end
        end
      end else if (imemREN) begin
        if (hw >= 0) begin
          if (m_hits != 32'hFFFF_FFFF) m_hits++;
          m_lru[s] = 1 - hw;
        end else begin
          if (m_misses != 32'hFFFF_FFFF) m_misses++;
          if (!m_valid[s][0])      v = 0;
          else if (!m_valid[s][1]) v = 1;
          else                     v = m_lru[s];
          m_filling = 1; m_fblk = blk; m_fway = v; m_fcnt = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int wait_left = 2;
  int wait_max  = 2;
  bit rand_wait = 0;

  function automatic int next_wait();
    return rand_wait ? int'($urandom_range(0, 3)) : wait_max;
  endfunction

  task automatic mem_respond();
    if (iREN) begin
      if (wait_left > 0) begin
        iwait = 1'b1; iload = $urandom; wait_left--;
      end else begin
        iwait = 1'b0; iload = memval(iaddr); wait_left = next_wait();
      end
    end else begin
      iwait = 1'($urandom_range(0, 1)); iload = $urandom; wait_left = next_wait();
    end
  endtask

  task automatic cyc(input bit rst, input bit ren, input logic [31:0] addr, input bit fl);
    @(posedge CLK); #1;
    RST = rst; imemREN = ren; imemaddr = addr; flush = fl;
    #1;
    mem_respond();
    @(negedge CLK);
  endtask

  // Hold a fetch until it hits; report hit cycle and the first two accepted word addresses.
  task automatic fetch(input logic [31:0] addr, output int hit_at,
                       output logic [31:0] acc0, output logic [31:0] acc1);
    int nacc;
    nacc = 0; hit_at = -1; acc0 = 32'd0; acc1 = 32'd0;
    for (int i = 0; i < 60; i++) begin
      cyc(1'b0, 1'b1, addr, 1'b0);
      if (iREN && !iwait) begin
        if (nacc == 0) acc0 = iaddr;
        else if (nacc == 1) acc1 = iaddr;
        nacc++;
      end
      if (ihit) begin
        hit_at = i;
        break;
      end
    end
    chk("fetch_hit_reached", 32'(ihit), 32'd1);
  endtask

  // Run a fetch until its first word is accepted.
  task automatic start_fill(input logic [31:0] addr);
    bit got;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      cyc(1'b0, 1'b1, addr, 1'b0);
      if (iREN && !iwait) got = 1;
    end
    chk("first_word_accepted", 32'(got), 32'd1);
  endtask

  initial begin
    int h;
    logic [31:0] a0, a1;
    bit r_rst, r_fl, r_ren;
    int r;
    logic [31:0] r_addr;

    cyc(1'b1, 1'b0, 32'd0, 1'b0);
    chk_en = 1;
    cyc(1'b1, 1'b0, 32'd0, 1'b0);
    chk("rst_ihit", 32'(ihit), 32'd0);
    chk("rst_imemload", imemload, 32'd0);
    chk("rst_iREN", 32'(iREN), 32'd0);
    chk("rst_iaddr", iaddr, 32'd0);
    chk("rst_miss_count", miss_count, 32'd0);
    cyc(1'b0, 1'b0, 32'd0, 1'b0);

    // Cold miss with two wait cycles per word.
    fetch(32'h100, h, a0, a1);
    chk("cold_hit_cycle", 32'(h), 32'd7);
    chk("cold_fill_addr0", a0, 32'h100);
    chk("cold_fill_addr1", a1, 32'h104);
    chk("cold_miss_count", miss_count, 32'd1);

    // Same-cycle hit on the second word.
    cyc(1'b0, 1'b1, 32'h104, 1'b0);
    chk("warm_ihit", 32'(ihit), 32'd1);
    chk("warm_word", imemload, memval(32'h104));
    cyc(1'b0, 1'b0, 32'd0, 1'b0);
    chk("warm_hit_count", hit_count, 32'd2);

    // LRU eviction inside set 0.
    fetch(32'h200, h, a0, a1); chk("x200_fill", 32'(h), 32'd7);
    fetch(32'h100, h, a0, a1); chk("x100_rehit", 32'(h), 32'd0);
    fetch(32'h300, h, a0, a1); chk("x300_fill", 32'(h), 32'd7);
    fetch(32'h100, h, a0, a1); chk("x100_kept", 32'(h), 32'd0);
    fetch(32'h200, h, a0, a1); chk("x200_evicted", 32'(h), 32'd7);
    chk("evict_miss_count", miss_count, 32'd4);

    // Flush during the second word of a fill.
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    start_fill(32'h100);
    cyc(1'b0, 1'b1, 32'h100, 1'b1);
    chk("flush_cycle_iaddr", iaddr, 32'h104);
    cyc(1'b0, 1'b0, 32'd0, 1'b0);
    chk("flush_next_iREN", 32'(iREN), 32'd0);
    chk("flush_next_iaddr", iaddr, 32'd0);
    fetch(32'h100, h, a0, a1);
    chk("flush_refetch_miss", 32'(h), 32'd7);
    chk("flush_miss_count", miss_count, 32'd6);

    // Reset in the middle of a fill.
    start_fill(32'h140);
    cyc(1'b1, 1'b0, 32'd0, 1'b0);
    cyc(1'b0, 1'b0, 32'd0, 1'b0);
    chk("midrst_miss_count", miss_count, 32'd0);
    chk("midrst_hit_count", hit_count, 32'd0);
    fetch(32'h140, h, a0, a1);
    chk("midrst_refill_cycle", 32'(h), 32'd7);
    chk("midrst_refill_addr0", a0, 32'h140);
    chk("midrst_refill_addr1", a1, 32'h144);
    chk("midrst_miss_once", miss_count, 32'd1);

    // Miss counter saturation.
    #1;
    force dut.miss_count_r = 32'hFFFF_FFFF;
    m_misses = 32'hFFFF_FFFF;
    #1;
    release dut.miss_count_r;
    cyc(1'b0, 1'b0, 32'd0, 1'b0);
    fetch(32'h180, h, a0, a1);
    chk("sat_fill", 32'(h), 32'd7);
    chk("sat_miss_count", miss_count, 32'hFFFF_FFFF);

    // Randomized traffic with random memory latency, flushes and resets.
    rand_wait = 1;
    for (int i = 0; i < 600; i++) begin
      r      = int'($urandom_range(0, 99));
      r_rst  = (r < 1);
      r_fl   = (r >= 1 && r < 4);
      r_ren  = ($urandom_range(0, 3) != 0);
      r_addr = (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 31)) << 2)
               | 32'($urandom_range(0, 3));
      cyc(r_rst, r_ren, r_addr, r_fl);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_assoc.md
ICACHE_ASSOC -- requirements
Module: icache_assoc

Interface
REQ-001 SHALL have parameter WAYS, default 2, meaning associativity; legal values 1 or 2.
REQ-002 SHALL have parameter SETS, default 8, meaning number of sets; power of two, 2..64.
REQ-003 SHALL have parameter BLKWORDS, default 2, meaning 32-bit words per block; legal values 1, 2 or 4.
REQ-004 CLK  in  1  single clock; all state updates on rising edge.
REQ-005 RST  in  1  reset, synchronous, active-high.
REQ-006 imemREN  in  1  datapath fetch request.
REQ-007 imemaddr  in  32  fetch byte address; bits [1:0] ignored.
REQ-008 ihit  out  1  fetch satisfied this cycle.
REQ-009 imemload  out  32  fetched instruction; valid when ihit=1, else 0.
REQ-010 iREN  out  1  memory read request.
REQ-011 iaddr  out  32  memory word address; 0 when iREN=0.
REQ-012 iwait  in  1  memory busy; iload valid in the cycle iwait=0 while iREN=1.
REQ-013 iload  in  32  memory read data.
REQ-014 flush  in  1  invalidate entire cache.
REQ-015 hit_count  out  32  saturating count of hit cycles.
REQ-016 miss_count  out  32  saturating count of misses (block fills started).

Function
REQ-017 Address split SHALL be: offset [1+log2(BLKWORDS):2], index next log2(SETS) bits, tag remaining upper bits.
REQ-018 Each way/set line SHALL hold valid, tag, BLKWORDS data words; each set SHALL hold one LRU bit (unused when WAYS=1).
REQ-019 FSM states SHALL be IDLE and FILL.
REQ-020 In IDLE with imemREN=1 and a valid tag match in any way: ihit=1 and imemload=matching word, combinationally, same cycle.
REQ-021 On a hit, the LRU bit SHALL be updated to point at the non-hit way.
REQ-022 In IDLE with imemREN=1 and no match: no ihit; latch block base address and victim way, clear word counter, enter FILL next cycle; miss_count increments once.
REQ-023 Victim SHALL be: first invalid way (way 0 preferred), else way named by LRU bit.
REQ-024 In FILL: iREN=1, iaddr=block base + 4*counter; on each cycle with iwait=0, write iload into victim word[counter] and increment counter.
REQ-025 On the write of the last word: set victim valid and tag, point LRU at the other way, return to IDLE; the request hits on the next cycle.
REQ-026 ihit SHALL be 0 throughout FILL; changes to imemaddr or imemREN during FILL SHALL NOT alter the fill in progress.
REQ-027 Lines SHALL be marked valid only after all BLKWORDS words are written; a partially filled line stays invalid.
REQ-028 flush=1 SHALL clear all valid and LRU bits at the clock edge; in FILL it aborts the fill and returns to IDLE, with iREN=0 next cycle.
REQ-029 flush SHALL take priority over a simultaneous hit or fill completion; ihit SHALL be 0 in a flush cycle.
REQ-030 hit_count and miss_count SHALL hold at 0xFFFFFFFF once reached; flush does not clear them.

Reset
REQ-031 RST=1 SHALL clear all valid, tag, data and LRU state, counters to 0, FSM to IDLE, and word counter to 0.
REQ-032 During and after reset, until the next request: ihit=0, imemload=0, iREN=0, iaddr=0.
REQ-033 RST asserted mid-FILL SHALL abandon the fill with no line marked valid.

Structure
REQ-034 icache state enum and the address field width helper constants SHALL reside in cpu_types_pkg.
REQ-035 Per-way storage (valid/tag/data array plus match compare) SHALL be a sub-module icache_way, instantiated WAYS times.

Verification (WAYS=2, SETS=8, BLKWORDS=2)
REQ-036 Cold fetch of 0x100, iwait=1 for 2 cycles per word -> iaddr 0x100 then 0x104; ihit=0 during the fill; ihit=1 the cycle after FILL exits; miss_count=1.
REQ-037 After REQ-036, fetch 0x104 -> same-cycle ihit=1 and imemload equal to the second loaded word; hit_count increments.
REQ-038 Fill 0x100 and 0x200 (set 0, ways 0/1), hit 0x100, then miss 0x300 -> way 1 (0x200) is evicted; 0x100 still hits and 0x200 misses.
REQ-039 flush asserted during the second word of a fill -> iREN=0 next cycle; FSM in IDLE; a refetch of 0x100 misses again.
REQ-040 RST asserted mid-fill, then fetch of the same address -> a new miss with a complete fill starting at word 0.
REQ-041 Preload miss_count to 0xFFFFFFFF (force) and trigger a miss -> value stays at 0xFFFFFFFF.
